// File: rtl/axis_frame_arbiter_if.sv
// Generic AXI-stream bundle: LANES parallel channels sharing one data bus.
// The master drives payload and valid; the slave returns ready.
interface axis_frame_arbiter_if #(
  parameter int unsigned LANES      = 1,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [LANES*DATA_WIDTH-1:0] data;
  logic [LANES-1:0]            valid;
  logic [LANES-1:0]            ready;
  logic [LANES-1:0]            last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-aware round-robin arbiter merging NUM_SRC AXI-stream sources into one
// registered stream; a grant is held from the first beat to the last of a frame.
module axis_frame_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_W       = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  axis_frame_arbiter_if.slave   s_axis,
  axis_frame_arbiter_if.master  m_axis,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ID_W-1:0]         r_grant;
  logic [ID_W-1:0]         w_grant_nxt;
  logic [ID_W-1:0]         r_rr_ptr;
  logic [ID_W-1:0]         w_rr_nxt;
  logic [ID_W-1:0]         w_pick;
  logic                    w_found;
  logic [2*NUM_SRC-1:0]    w_valid_dbl;
  logic [NUM_SRC-1:0]      w_valid_rot;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_slot_free;
  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   r_m_data;
  logic [DATA_WIDTH-1:0]   w_m_data_nxt;
  logic                    r_m_valid;
  logic                    w_m_valid_nxt;
  logic                    r_m_last;
  logic                    w_m_last_nxt;
  logic [CNT_W-1:0]        r_frame_cnt;
  logic [CNT_W-1:0]        w_frame_cnt_nxt;
  logic                    r_busy;

  // Rotate valids so index 0 is the source at rr_ptr; first set bit wins.
  assign w_valid_dbl = {s_axis.valid, s_axis.valid};
  assign w_valid_rot = NUM_SRC'(w_valid_dbl >> r_rr_ptr);

  always_comb begin : rr_search
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (!w_found && w_valid_rot[k]) begin
        w_found = 1'b1;
        if (int'(r_rr_ptr) + k >= int'(NUM_SRC)) begin
          w_pick = ID_W'(int'(r_rr_ptr) + k - int'(NUM_SRC));
        end else begin
          w_pick = ID_W'(int'(r_rr_ptr) + k);
        end
      end
    end
  end

  always_comb begin : grant_mux
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (r_grant == ID_W'(i)) begin
        w_sel_valid = s_axis.valid[i];
        w_sel_last  = s_axis.last[i];
        w_sel_data  = s_axis.data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The output slot can take a beat when empty or draining this cycle.
  assign w_slot_free = !r_m_valid || m_axis.ready;
  assign w_accept    = (r_state == ST_XFER) && w_slot_free && w_sel_valid;

  always_comb begin : src_ready
    s_axis.ready = '0;
    if (r_state == ST_XFER && w_slot_free) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        s_axis.ready[i] = (r_grant == ID_W'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : next_state
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_found)                 w_state_nxt = ST_XFER;
      ST_XFER: if (w_accept && w_sel_last)  w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin : output_next
    w_grant_nxt     = r_grant;
    w_rr_nxt        = r_rr_ptr;
    w_frame_cnt_nxt = r_frame_cnt;
    w_m_data_nxt    = r_m_data;
    w_m_last_nxt    = r_m_last;
    w_m_valid_nxt   = r_m_valid;
    if (r_state == ST_IDLE && w_found) begin
      w_grant_nxt = w_pick;
    end
    if (w_accept) begin
      w_m_data_nxt  = w_sel_data;
      w_m_last_nxt  = w_sel_last;
      w_m_valid_nxt = 1'b1;
      if (w_sel_last) begin
        w_rr_nxt        = (r_grant == ID_W'(NUM_SRC - 1)) ? '0 : r_grant + ID_W'(1);
        w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
      end
    end else if (r_m_valid && m_axis.ready) begin
      w_m_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : out_regs
    if (!reset_n) begin
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_frame_cnt <= '0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_m_valid   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_m_data    <= w_m_data_nxt;
      r_m_last    <= w_m_last_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_busy      <= (w_state_nxt == ST_XFER);
    end
  end

  assign m_axis.data  = r_m_data;
  assign m_axis.valid = r_m_valid;
  assign m_axis.last  = r_m_last;
  assign grant_id     = r_grant;
  assign busy         = r_busy;
  assign frame_cnt    = r_frame_cnt;
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench for axis_frame_arbiter: per-source frame queues, a
// round-robin frame-order model, and per-scenario timing checks.
module tb_axis_frame_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [IDW-1:0]  grant_id;
  logic            busy;
  logic [15:0]     frame_cnt;

  always #5 clk = ~clk;

  axis_frame_arbiter_if #(.LANES(N), .DATA_WIDTH(DW)) s_if ();
  axis_frame_arbiter_if #(.LANES(1), .DATA_WIDTH(DW)) m_if ();

  axis_frame_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .ID_W(IDW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .grant_id  (grant_id),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t srcq[N][$];
  beat_t exp_acc[$];
  beat_t exp_out[$];
  int    acc_cyc[$];
  int    out_cyc[$];
  int    frm_start[$];
  int    frm_end[$];
  int    m_rr;
  int    exp_frames;
  bit    mid[N];
  int    bidx[N];
  int    gap_left[N];
  int    gap_src = -1;
  int    gap_after;
  int    gap_len;
  int    gap_pct = 0;
  int    ready_pct = 100;
  bit    use_pat = 1'b0;
  bit [4:0] pat = 5'b11001;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic clear_model();
    for (int s = 0; s < int'(N); s++) begin
      srcq[s].delete();
      mid[s] = 1'b0;
      bidx[s] = 0;
      gap_left[s] = 0;
    end
    exp_acc.delete();
    exp_out.delete();
    m_rr = 0;
    exp_frames = 0;
  endtask

  task automatic add_frame(input int s, input int len, input logic [DW-1:0] base, input bit use_base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.src  = s;
      b.data = use_base ? base + DW'(i) : DW'($urandom);
      b.last = (i == len - 1);
      srcq[s].push_back(b);
    end
  endtask

  // Frame order from the round-robin rule: pointer search, whole frame, pointer past winner.
  task automatic build_expected();
    int    pos[N];
    int    pick;
    int    s;
    beat_t b;
    for (int i = 0; i < int'(N); i++) pos[i] = 0;
    while (1) begin
      pick = -1;
      for (int k = 0; k < int'(N); k++) begin
        s = (m_rr + k) % int'(N);
        if (pick < 0 && pos[s] < srcq[s].size()) pick = s;
      end
      if (pick < 0) break;
      do begin
        b = srcq[pick][pos[pick]];
        pos[pick]++;
        exp_acc.push_back(b);
        exp_out.push_back(b);
      end while (!b.last);
      m_rr = (pick + 1) % int'(N);
      exp_frames++;
    end
  endtask

  task automatic run(input int max_cyc, input int stop_acc);
    int            cyc;
    int            tail;
    int            n_acc;
    bit            prev_stall;
    bit            stall_now;
    bit            aborted;
    bit            blocked;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    logic [N-1:0]  exp_r;
    beat_t         eb;
    beat_t         b;
    acc_cyc.delete(); out_cyc.delete(); frm_start.delete(); frm_end.delete();
    build_expected();
    cyc = 0; tail = 0; n_acc = 0; prev_stall = 1'b0; aborted = 1'b0;
    prev_d = '0; prev_l = 1'b0;
    while (1) begin
      @(negedge clk);
      for (int s = 0; s < int'(N); s++) begin
        blocked = 1'b0;
        if (mid[s] && gap_left[s] > 0) begin
          blocked = 1'b1;
          gap_left[s]--;
        end else if (mid[s] && int'($urandom_range(99)) < gap_pct) begin
          blocked = 1'b1;
        end
        if (srcq[s].size() > 0) begin
          s_if.valid[s]           = !blocked;
          s_if.data[s*DW +: DW]   = srcq[s][0].data;
          s_if.last[s]            = srcq[s][0].last;
        end else begin
          s_if.valid[s] = 1'b0;
          s_if.last[s]  = 1'b0;
        end
      end
      m_if.ready = use_pat ? pat[cyc % 5] : (int'($urandom_range(99)) < ready_pct);
      #1;
      if (prev_stall) begin
        n_checks++;
        if (m_if.data !== prev_d || m_if.last !== prev_l)
          $display("FAIL hold_stable cyc=%0d got data=%h last=%b want data=%h last=%b", cyc, m_if.data, m_if.last, prev_d, prev_l);
        else n_pass++;
      end
      stall_now  = m_if.valid && !m_if.ready;
      prev_stall = stall_now;
      prev_d     = m_if.data;
      prev_l     = m_if.last;
      if (s_if.ready != '0) begin
        exp_r = N'(1) << grant_id;
        n_checks++;
        if (s_if.ready !== exp_r || busy !== 1'b1 || stall_now)
          $display("FAIL ready_grant cyc=%0d got ready=%b busy=%b stall=%b want ready=%b busy=1 stall=0", cyc, s_if.ready, busy, stall_now, exp_r);
        else n_pass++;
      end
      for (int s = 0; s < int'(N); s++) begin
        if (s_if.valid[s] && s_if.ready[s]) begin
          b = srcq[s].pop_front();
          n_checks++;
          if (exp_acc.size() == 0) begin
            $display("FAIL accept_extra cyc=%0d got src=%0d want no accept", cyc, s);
          end else begin
            eb = exp_acc.pop_front();
            if (eb.src != s || eb.data !== b.data)
              $display("FAIL accept_order cyc=%0d got src=%0d data=%h want src=%0d data=%h", cyc, s, b.data, eb.src, eb.data);
            else n_pass++;
          end
          if (!mid[s]) frm_start.push_back(cyc);
          if (b.last) frm_end.push_back(cyc);
          mid[s] = !b.last;
          bidx[s] = b.last ? 0 : bidx[s] + 1;
          if (s == gap_src && !b.last && bidx[s] == gap_after) gap_left[s] = gap_len;
          acc_cyc.push_back(cyc);
          n_acc++;
        end
      end
      if (m_if.valid && m_if.ready) begin
        n_checks++;
        if (exp_out.size() == 0) begin
          $display("FAIL out_extra cyc=%0d got data=%h want no beat", cyc, m_if.data);
        end else begin
          eb = exp_out.pop_front();
          if (m_if.data !== eb.data || m_if.last !== eb.last)
            $display("FAIL out_beat cyc=%0d got data=%h last=%b want data=%h last=%b", cyc, m_if.data, m_if.last, eb.data, eb.last);
          else n_pass++;
        end
        out_cyc.push_back(cyc);
      end
      cyc++;
      if (stop_acc > 0 && n_acc >= stop_acc) begin
        aborted = 1'b1;
        break;
      end
      if (exp_acc.size() == 0 && exp_out.size() == 0) tail++;
      if (tail > 3) break;
      if (cyc >= max_cyc) begin
        n_checks++;
        $display("FAIL timeout got pending_acc=%0d pending_out=%0d want 0/0", exp_acc.size(), exp_out.size());
        break;
      end
    end
    if (!aborted) begin
      n_checks++;
      if (frame_cnt !== 16'(exp_frames))
        $display("FAIL frame_cnt got %0d want %0d", frame_cnt, exp_frames);
      else n_pass++;
    end
  endtask

  task automatic do_reset();
    s_if.valid = '0;
    s_if.last  = '0;
    clear_model();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_model();
    reset_n    = 1'b0;
    s_if.valid = '1;
    s_if.last  = '0;
    s_if.data  = {N{32'hDEAD_BEEF}};
    m_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (m_if.valid !== 1'b0) $display("FAIL rst_m_valid got %b want 0", m_if.valid); else n_pass++;
    n_checks++; if (m_if.data !== '0) $display("FAIL rst_m_data got %h want 0", m_if.data); else n_pass++;
    n_checks++; if (m_if.last !== 1'b0) $display("FAIL rst_m_last got %b want 0", m_if.last); else n_pass++;
    n_checks++; if (grant_id !== '0) $display("FAIL rst_grant got %0d want 0", grant_id); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd0) $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
    n_checks++; if (s_if.ready !== '0) $display("FAIL rst_s_ready got %b want 0", s_if.ready); else n_pass++;
    s_if.valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_frame();
    add_frame(1, 4, 32'h11, 1'b1);
    run(100, 0);
    n_checks++;
    if (out_cyc.size() != 4 || acc_cyc.size() != 4)
      $display("FAIL single_count got out=%0d acc=%0d want 4/4", out_cyc.size(), acc_cyc.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < out_cyc.size() && acc_cyc.size() > 0; i++) begin
      n_checks++;
      if (out_cyc[i] != acc_cyc[0] + 1 + i)
        $display("FAIL single_latency beat=%0d got cyc=%0d want %0d", i, out_cyc[i], acc_cyc[0] + 1 + i);
      else n_pass++;
    end
  endtask

  task automatic test_two_sources();
    do_reset();
    add_frame(0, 2, 32'hA0, 1'b1);
    add_frame(2, 2, 32'hB0, 1'b1);
    add_frame(0, 2, 32'hA2, 1'b1);
    add_frame(2, 2, 32'hB2, 1'b1);
    run(200, 0);
    for (int i = 0; i < 3 && i + 1 < frm_start.size() && i < frm_end.size(); i++) begin
      n_checks++;
      if (frm_start[i+1] != frm_end[i] + 2)
        $display("FAIL frame_gap idx=%0d got start=%0d want %0d", i, frm_start[i+1], frm_end[i] + 2);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    use_pat = 1'b1;
    add_frame(3, 5, 32'h300, 1'b1);
    run(200, 0);
    use_pat = 1'b0;
    n_checks++;
    if (out_cyc.size() != 5 || acc_cyc.size() != 5)
      $display("FAIL bp_count got out=%0d acc=%0d want 5/5", out_cyc.size(), acc_cyc.size());
    else n_pass++;
  endtask

  task automatic test_mid_gap();
    do_reset();
    gap_src = 0; gap_after = 2; gap_len = 5;
    add_frame(0, 4, 32'hC0, 1'b1);
    add_frame(1, 2, 32'hD0, 1'b1);
    run(200, 0);
    gap_src = -1;
    n_checks++;
    if (frm_end.size() < 1 || frm_start.size() < 1 || frm_end[0] - frm_start[0] != 8)
      $display("FAIL gap_span got %0d want 8", (frm_end.size() > 0 && frm_start.size() > 0) ? frm_end[0] - frm_start[0] : -1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_frame(2, 1, 32'h20, 1'b1);
    run(100, 0);
    add_frame(3, 4, 32'h30, 1'b1);
    run(100, 2);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (m_if.valid !== 1'b0) $display("FAIL rmid_m_valid got %b want 0", m_if.valid); else n_pass++;
    n_checks++; if (frame_cnt !== 16'd0) $display("FAIL rmid_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (s_if.ready !== '0) $display("FAIL rmid_s_ready got %b want 0", s_if.ready); else n_pass++;
    s_if.valid = '0;
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
    add_frame(2, 2, 32'h50, 1'b1);
    add_frame(3, 2, 32'h60, 1'b1);
    run(200, 0);
  endtask

  task automatic test_all_single();
    do_reset();
    for (int s = 0; s < int'(N); s++) add_frame(s, 1, '0, 1'b0);
    add_frame(0, 1, '0, 1'b0);
    run(200, 0);
    for (int i = 0; i + 1 < out_cyc.size(); i++) begin
      n_checks++;
      if (out_cyc[i+1] - out_cyc[i] != 2)
        $display("FAIL single_rate idx=%0d got spacing=%0d want 2", i, out_cyc[i+1] - out_cyc[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    gap_pct = 20;
    ready_pct = 60;
    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < int'(N); s++) begin
        int nfr;
        nfr = int'($urandom_range(2));
        for (int f = 0; f < nfr; f++) add_frame(s, int'($urandom_range(5, 1)), '0, 1'b0);
      end
      run(3000, 0);
    end
    gap_pct = 0;
    ready_pct = 100;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_if.valid = '0;
    s_if.last  = '0;
    s_if.data  = '0;
    m_if.ready = 1'b1;
    test_reset();
    test_single_frame();
    test_two_sources();
    test_backpressure();
    test_mid_gap();
    test_reset_mid();
    test_all_single();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Frame-aware round-robin arbiter that shares one AXI-stream FIFO write port among NUM_SRC AXI-stream sources.
- Sits upstream of the FIFO. Its master side drives the FIFO's slave stream interface.
- Grants one source at a time and holds the grant until that source's last beat, so frames never interleave.
- Output is registered (one-entry pipeline stage) with full-throughput backpressure handling.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DATA_WIDTH, 32, stream data width in bits.
- ID_W, 2, width of grant_id; must be at least ceil(log2(NUM_SRC)).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- s_axis_data  input  NUM_SRC*DATA_WIDTH  source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_valid  input  NUM_SRC  per-source valid.
- s_axis_ready  output  NUM_SRC  per-source ready, combinational.
- s_axis_last  input  NUM_SRC  per-source end-of-frame.
- m_axis_data  output  DATA_WIDTH  registered data to the FIFO.
- m_axis_valid  output  1  registered valid.
- m_axis_ready  input  1  FIFO ready / not-full.
- m_axis_last  output  1  registered end-of-frame.
- grant_id  output  ID_W  index of the currently granted source.
- busy  output  1  high while in XFER.
- frame_cnt  output  16  count of completed frames, wraps.

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, rr_ptr=0, grant_id=0.
  - m_axis_data=0, m_axis_valid=0, m_axis_last=0.
  - frame_cnt=0, busy=0.
  - s_axis_ready=0 while reset is asserted.
- State machine, two states:
  - IDLE: each cycle, search s_axis_valid starting at index rr_ptr and wrapping modulo NUM_SRC. The first set bit g is registered into grant_id and the state moves to XFER. If no valid is set, stay in IDLE.
  - XFER: s_axis_ready[grant_id] = (!m_axis_valid || m_axis_ready). All other s_axis_ready bits are 0. In IDLE all s_axis_ready bits are 0.
- Accept, defined as s_axis_valid[g] && s_axis_ready[g]:
  - The output register loads data[g] and last[g], and m_axis_valid is set to 1.
  - If the accepted beat has last=1: next state is IDLE, rr_ptr = (g+1) mod NUM_SRC, frame_cnt increments by 1 (wrapping 0xFFFF to 0).
- Output register:
  - If m_axis_valid && m_axis_ready and there is no new accept in the same cycle, m_axis_valid clears to 0.
  - If both happen in the same cycle, the register reloads and m_axis_valid stays 1.
  - m_axis_data and m_axis_last must not change while m_axis_valid=1 && m_axis_ready=0.
- Latency and throughput:
  - An accepted beat appears on m_axis one cycle later.
  - Sustained rate is 1 beat per clock within a frame while m_axis_ready=1.
  - Exactly one arbitration cycle (IDLE) separates consecutive frames.
- Boundaries:
  - Single-beat frame (valid and last in the first beat): XFER lasts one accept, then return to IDLE.
  - Granted source deasserts valid mid-frame: the grant is held indefinitely. There is no timeout and no preemption.
  - Other sources' valid in XFER is ignored. Their s_axis_ready stays 0.
  - m_axis_ready low with the register full: granted s_axis_ready=0 and no beat is lost.
  - IDLE with m_axis_valid still 1: arbitration proceeds. The new grant's ready then follows the rule above.
  - Reset mid-frame: everything returns to reset values immediately. Any partial frame in the output register is discarded.
  - rr_ptr wrap: from NUM_SRC-1, rr_ptr goes to 0.
  - The grant_id value is meaningful only when busy=1.

Test Plan:
- Single source 1 sends a 4-beat frame (data 0x11..0x14, last on beat 4), m_axis_ready=1. Required: m_axis carries 0x11..0x14 on consecutive cycles starting one cycle after the first accept; m_axis_last only on 0x14; grant_id=1; frame_cnt=1.
- Sources 0 and 2 each hold valid with 2-beat frames continuously from reset. Required grant order: 0, 2, 0, 2; one IDLE cycle between frames; frame_cnt=4 after 4 frames.
- Source 3 is granted and m_axis_ready toggles 1,0,0,1,1. Required: no beat is dropped or duplicated; m_axis_data is held stable during ready=0; s_axis_ready[3]=0 while the register is full and stalled.
- Source 0 is mid-frame with a gap where valid=0 for 5 cycles, while source 1 is valid throughout. Required: s_axis_ready[1] stays 0 until source 0's last beat; then grant goes to 1.
- reset_n is pulsed low during beat 2 of a 4-beat frame. Required: m_axis_valid=0, frame_cnt=0 and busy=0 immediately. After release, a fresh frame from source 2 is granted first (rr_ptr=0 search finds 2).
- All 4 sources send single-beat frames continuously. Required grant order: 0,1,2,3,0; one output beat every 2 cycles; m_axis_last=1 on every beat.
